decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32 decode stage: instruction decode into a bundle plus a small
// output FIFO, with fence/WFI issue holds and flush.
package decode_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  inst_type;
    logic [3:0]  alu_ctrl;
    logic [1:0]  wb_sel;
    logic        alu_sr1_sel;
    logic        alu_sr2_sel;
    logic        reg_we;
    logic        mem_we;
    logic        is_jump;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        fence;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [15:0] exp_code;
    logic        is_mret;
    logic        is_wfi;
    logic        is_muldiv;
  } dec_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HOLD_FENCE = 2'd1,
    HOLD_WFI   = 2'd2
  } st_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_MISC = 7'b0001111;

endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter bit EN_M  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [99:0] out_dec,
  input  logic        flush,
  input  logic        fence_done,
  input  logic        irq_pending
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  logic is_r, is_s, is_b, is_j, is_u, is_i;
  logic is_ld, is_sys, is_misc, is_si, is_jalr;
  logic known, m_enc, m_bad, csr_we;

  dec_t dec_d;

  assign opcode = in_inst[6:0];
  assign funct7 = in_inst[31:25];
  assign funct3 = in_inst[14:12];

  always_comb begin
    is_r    = (opcode == OP_R);
    is_s    = (opcode == OP_S);
    is_b    = (opcode == OP_B);
    is_j    = (opcode == OP_JAL);
    is_u    = (opcode == OP_LUI) || (opcode == OP_AUI);
    is_jalr = (opcode == OP_JALR);
    is_ld   = (opcode == OP_LD);
    is_i    = (opcode == OP_IMM) || is_jalr || is_ld;
    is_sys  = (opcode == OP_SYS);
    is_misc = (opcode == OP_MISC);
    is_si   = (opcode == OP_IMM) && (funct3[1:0] == 2'b01);
    known   = is_r | is_s | is_b | is_j | is_u
            | is_i | is_sys | is_misc;
    m_enc   = is_r && (funct7 == 7'b0000001);
    m_bad   = m_enc && !EN_M;
    csr_we  = is_sys && (funct3 != 3'b000);
  end

  always_comb begin
    dec_d             = '0;
    dec_d.pc          = in_pc;
    dec_d.inst_type   = {is_i, is_j, is_u, is_b, is_s, is_r};
    dec_d.is_muldiv   = m_enc && EN_M;
    dec_d.funct3      = funct3;
    dec_d.rs1         = in_inst[19:15];
    dec_d.rs2         = in_inst[24:20];
    dec_d.rd          = in_inst[11:7];
    dec_d.csr_addr    = in_inst[31:20];
    dec_d.alu_sr1_sel = is_j | is_b | is_u;
    dec_d.alu_sr2_sel = !is_r;
    dec_d.mem_we      = is_s;
    dec_d.is_jump     = is_j | is_jalr;
    dec_d.fence       = is_misc;
    dec_d.csr_we      = csr_we;
    dec_d.reg_we      = (is_r | is_i | is_u | is_j | csr_we)
                      & !m_bad;
    dec_d.wb_sel      = {dec_d.is_jump, is_ld}
                      | {csr_we, csr_we};
    dec_d.is_mret     = is_sys && (funct3 == 3'b000)
                      && (in_inst[31:20] == 12'h302);
    dec_d.is_wfi      = is_sys && (funct3 == 3'b000)
                      && (in_inst[31:20] == 12'h105);
    dec_d.exp_code[2] = !known || m_bad;
    dec_d.exp_code[3] = is_sys
                      && (in_inst[31:7] == 25'h0002000);
    dec_d.exp_code[11] = is_sys
                       && (in_inst[31:7] == 25'h0);
    // first match wins; M ops share the R opcode
    if (opcode == OP_LUI)
      dec_d.alu_ctrl = 4'b1111;
    else if (dec_d.is_muldiv)
      dec_d.alu_ctrl = 4'b0000;
    else if (is_r || is_si)
      dec_d.alu_ctrl = {funct3, in_inst[30]};
    else if (is_i && !is_ld)
      dec_d.alu_ctrl = {funct3, 1'b0};
    else if (is_sys)
      dec_d.alu_ctrl = 4'b1101;
    else
      dec_d.alu_ctrl = 4'b0000;
  end

  dec_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  st_e           state_q, state_d;
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = rst_n && (count_q < CW'(DEPTH))
                  && (state_q == RUN) && !flush;
  assign out_valid = (count_q != '0);
  assign out_dec   = mem_q[rd_ptr_q];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (push && dec_d.fence)
            state_d = HOLD_FENCE;
          else if (push && dec_d.is_wfi)
            state_d = HOLD_WFI;
        end
        HOLD_FENCE: if (fence_done) state_d = RUN;
        HOLD_WFI:   if (irq_pending) state_d = RUN;
        default:    state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= RUN;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // payload storage carries no reset; out_valid qualifies it
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_d;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: two instances (with and
// without M) checked against a queue-based reference model.
module tb_decode_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        fence_done = 1'b0;
  logic        irq_pending = 1'b0;

  logic        in_ready, out_valid;
  logic [99:0] out_dec;
  logic        in_ready_nm, out_valid_nm;
  logic [99:0] out_dec_nm;

  int n_chk = 0;
  int n_err = 0;

  logic [99:0] q_m[$];
  logic [99:0] q_nm[$];
  int          st = 0;

  always #5 clk = ~clk;

  decode_stage #(.DEPTH(DEPTH), .EN_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dec(out_dec), .flush(flush),
    .fence_done(fence_done), .irq_pending(irq_pending)
  );

  decode_stage #(.DEPTH(DEPTH), .EN_M(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_nm),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid_nm), .out_ready(out_ready),
    .out_dec(out_dec_nm), .flush(flush),
    .fence_done(fence_done), .irq_pending(irq_pending)
  );

  task automatic chk(input string tag,
                     input logic [99:0] got,
                     input logic [99:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [99:0] ref_dec(
    input logic [31:0] inst,
    input logic [31:0] pc,
    input bit          en_m
  );
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [15:0] exc;
    bit r, s, b, j, u, i, sys, mm, ld, jr, known;
    bit m_enc, md, bad, cw, we, jmp, mret, wfi;
    op    = inst[6:0];
    f3    = inst[14:12];
    r     = (op == 7'h33);
    s     = (op == 7'h23);
    b     = (op == 7'h63);
    j     = (op == 7'h6f);
    u     = (op == 7'h37) || (op == 7'h17);
    ld    = (op == 7'h03);
    jr    = (op == 7'h67);
    i     = (op == 7'h13) || jr || ld;
    sys   = (op == 7'h73);
    mm    = (op == 7'h0f);
    known = r || s || b || j || u || i || sys || mm;
    m_enc = r && (inst[31:25] == 7'd1);
    md    = m_enc && en_m;
    bad   = !known || (m_enc && !en_m);
    if (op == 7'h37)                         alu = 4'hF;
    else if (md)                             alu = 4'h0;
    else if (r || (op == 7'h13 && f3[1:0] == 2'b01))
                                             alu = {f3, inst[30]};
    else if (i && !ld)                       alu = {f3, 1'b0};
    else if (sys)                            alu = 4'hD;
    else                                     alu = 4'h0;
    cw   = sys && (f3 != 0);
    we   = (r || i || u || j || cw) && !(m_enc && !en_m);
    jmp  = j || jr;
    mret = sys && f3 == 0 && inst[31:20] == 12'h302;
    wfi  = sys && f3 == 0 && inst[31:20] == 12'h105;
    exc  = '0;
    exc[2]  = bad;
    exc[3]  = sys && (inst[31:7] == 25'h0002000);
    exc[11] = sys && (inst[31:7] == 25'h0);
    return {pc, i, j, u, b, s, r, alu,
            jmp || cw, ld || cw,
            j || b || u, !r, we, s, jmp, f3,
            inst[19:15], inst[24:20], inst[11:7],
            mm, cw, inst[31:20], exc, mret, wfi, md};
  endfunction

  task automatic cyc(input bit v, input logic [31:0] ins,
                     input logic [31:0] pc, input bit ordy,
                     input bit fl, input bit fd, input bit irq);
    bit exp_rdy, push, pop;
    @(negedge clk);
    in_valid = v; in_inst = ins; in_pc = pc;
    out_ready = ordy; flush = fl;
    fence_done = fd; irq_pending = irq;
    #1;
    exp_rdy = (q_m.size() < DEPTH) && st == 0 && !fl;
    chk("in_ready", in_ready, exp_rdy);
    chk("in_ready_nm", in_ready_nm, exp_rdy);
    chk("out_valid", out_valid, q_m.size() != 0);
    chk("out_valid_nm", out_valid_nm, q_m.size() != 0);
    if (q_m.size() != 0) begin
      chk("out_dec", out_dec, q_m[0]);
      chk("out_dec_nm", out_dec_nm, q_nm[0]);
    end
    push = v && exp_rdy;
    pop  = (q_m.size() != 0) && ordy;
    if (fl) begin
      q_m.delete(); q_nm.delete(); st = 0;
    end else begin
      if (pop) begin
        void'(q_m.pop_front());
        void'(q_nm.pop_front());
      end
      if (push) begin
        q_m.push_back(ref_dec(ins, pc, 1'b1));
        q_nm.push_back(ref_dec(ins, pc, 1'b0));
      end
      if (st == 0 && push && ins[6:0] == 7'h0f) st = 1;
      else if (st == 0 && push && ins[6:0] == 7'h73
               && ins[14:12] == 3'd0
               && ins[31:20] == 12'h105) st = 2;
      else if (st == 1 && fd) st = 0;
      else if (st == 2 && irq) st = 0;
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  ops [11];
    logic [31:0] sp [8];
    ops = '{7'h33, 7'h23, 7'h63, 7'h6f, 7'h37, 7'h17,
            7'h13, 7'h67, 7'h03, 7'h73, 7'h0f};
    sp  = '{32'h0000000F, 32'h10500073, 32'h30200073,
            32'h00000073, 32'h00100073, 32'h02208033,
            32'h00500093, 32'h40A5D513};
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r = sp[$urandom_range(0, 7)];
      1: ;
      2: r = {7'h01, r[24:7], 7'h33};
      default: r[6:0] = ops[$urandom_range(0, 10)];
    endcase
    return r;
  endfunction

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x0,5 then observe next cycle
    cyc(1, 32'h00500093, 32'h100, 1, 0, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
    chk("addi_type", out_dec[67:62], 6'b100000);
    chk("addi_alu", out_dec[61:58], 4'b0000);
    chk("addi_sr2", out_dec[54], 1'b1);
    chk("addi_we", out_dec[53], 1'b1);
    chk("addi_rd", out_dec[37:33], 5'd1);
    chk("addi_rdy", in_ready, 1'b1);

    // fill with out_ready low, then drain and wrap
    cyc(1, 32'h00100113, 32'h200, 0, 0, 0, 0);
    cyc(1, 32'h00200193, 32'h204, 0, 0, 0, 0);
    cyc(1, 32'h00300213, 32'h208, 0, 0, 0, 0);
    chk("full_block", in_ready, 1'b0);
    for (int k = 0; k < 6; k++)
      cyc(1, 32'h00400293 + 32'(k << 20),
          32'h300 + 32'(4 * k), 1, 0, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);

    // fence hold
    cyc(1, 32'h0000000F, 32'h400, 1, 0, 0, 0);
    cyc(1, 32'h00500093, 32'h404, 1, 0, 0, 1);
    chk("fence_hold", in_ready, 1'b0);
    cyc(0, 32'h0, 32'h0, 1, 0, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
    chk("fence_rel", in_ready, 1'b1);

    // wfi hold
    cyc(1, 32'h10500073, 32'h500, 0, 0, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 0, 1, 0);
    chk("wfi_flag", out_dec[1], 1'b1);
    chk("wfi_hold", in_ready, 1'b0);
    cyc(0, 32'h0, 32'h0, 1, 0, 0, 1);
    cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
    chk("wfi_rel", in_ready, 1'b1);

    // M extension and ecall
    cyc(1, 32'h02208033, 32'h600, 0, 0, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
    chk("mul_md", out_dec[0], 1'b1);
    chk("mul_alu", out_dec[61:58], 4'b0000);
    chk("mul_nm_exc", out_dec_nm[18:3], 16'h0004);
    chk("mul_nm_we", out_dec_nm[53], 1'b0);
    cyc(1, 32'h00000073, 32'h700, 0, 0, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
    chk("ecall_exc", out_dec[18:3], 16'h0800);

    // full + fence hold, then flush
    cyc(1, 32'h00100113, 32'h800, 0, 0, 0, 0);
    cyc(1, 32'h0000000F, 32'h804, 0, 0, 0, 0);
    cyc(1, 32'h00200193, 32'h808, 1, 1, 0, 0);
    cyc(0, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("flush_ov", out_valid, 1'b0);
    chk("flush_rdy", in_ready, 1'b1);

    for (int k = 0; k < 2000; k++)
      cyc($urandom_range(0, 3) != 0, rand_inst(), $urandom,
          $urandom_range(0, 9) < 6,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) == 0);

    // asynchronous reset mid-stream
    cyc(1, 32'h00100113, 32'h900, 0, 0, 0, 0);
    cyc(1, 32'h00200193, 32'h904, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", out_valid, 1'b0);
    chk("arst_rdy", in_ready, 1'b0);
    q_m.delete(); q_nm.delete(); st = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++)
      cyc(1, rand_inst(), $urandom, 1, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
